ad_sample_scheduler: RTL and testbench

// - Conversion sequencer for the PmodAD1 SPI ADC controller; sits between that controller and the FIR datapath.
// - Issues start_conv at a programmable sample period and never while a conversion is in flight.
// - Guards each conversion with a timeout watchdog.
// - Buffers results in a small FIFO with valid/ready to the filter; counts overruns and drops for software.

---
 rtl/ad_sched_pkg.sv | 26 ++
 rtl/ad_sample_scheduler_if.sv | 19 +
 rtl/sample_fifo.sv | 74 +++++++
 rtl/ad_sample_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_ad_sample_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ad_sched_pkg.sv
// ---------------------------------------------------------------------------
// ad_sched_pkg
// Shared types and constants for the PmodAD1 conversion sequencer.
//   sched_state_t : sequencer states (IDLE, ARMED, BUSY, DRAIN)
//   ADC_W         : ADC sample width
//   CNT_W         : width of the software-visible status counters
//   sat_inc()     : saturating increment for the status counters
// ---------------------------------------------------------------------------
package ad_sched_pkg;

    localparam int ADC_W = 12;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BUSY  = 2'd2,
        DRAIN = 2'd3
    } sched_state_t;

    // Counters stick at all-ones so software can tell "many" from "wrapped".
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ad_sample_scheduler_if.sv
// ---------------------------------------------------------------------------
// ad_sample_scheduler_if
// Valid/ready sample stream from the sequencer to the FIR datapath.
//   m_data  : sample (ADC_W bits)
//   m_valid : m_data holds a sample
//   m_ready : consumer accepts when m_valid & m_ready
// Modports: master (sequencer side), slave (filter side).
// ---------------------------------------------------------------------------
interface ad_sample_scheduler_if;
    import ad_sched_pkg::*;

    logic [ADC_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
// Synchronous FIFO with first-word-fall-through output.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : write push_data_i (ignored when full unless popping too)
//   push_data_i  : write data
//   pop_i        : remove head entry (ignored when empty)
//   pop_data_o   : current head entry, valid while !empty_o
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);

    // A pop frees the slot, so a push into a full FIFO succeeds when it
    // coincides with a pop.
    assign do_pop  = pop_i  && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign pop_data_o = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count gates every read, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ad_sample_scheduler.sv
// ---------------------------------------------------------------------------
// ad_sample_scheduler
// Conversion sequencer between the PmodAD1 SPI controller and the FIR.
// Issues start_conv at a programmable period (never while a conversion is
// in flight), guards each conversion with a watchdog, buffers results in a
// small FIFO and keeps saturating overrun/drop counters for software.
//   clk, rst        : clock, synchronous active-high reset
//   enable_i        : run/stop sampling
//   period_cfg_i    : sample period in cycles (below MIN_PERIOD -> MIN_PERIOD)
//   clr_status_i    : clear counters and timeout flag
//   start_conv_o    : one-cycle conversion request to the ADC controller
//   conv_done_i     : ADC controller completion pulse
//   adc_data_i      : ADC result, qualified by data_valid_i
//   data_valid_i    : ADC result strobe
//   m_if            : valid/ready sample stream to the FIR (master side)
//   busy_o          : conversion in flight
//   overrun_cnt_o   : period ticks skipped because a conversion was in flight
//   drop_cnt_o      : samples lost to a full FIFO
//   timeout_flag_o  : sticky watchdog expiry flag
// ---------------------------------------------------------------------------
module ad_sample_scheduler
    import ad_sched_pkg::*;
#(
    parameter int DIV_W          = 20,
    parameter int MIN_PERIOD     = 128,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic [DIV_W-1:0]      period_cfg_i,
    input  logic                  clr_status_i,
    output logic                  start_conv_o,
    input  logic                  conv_done_i,
    input  logic [ADC_W-1:0]      adc_data_i,
    input  logic                  data_valid_i,
    ad_sample_scheduler_if.master m_if,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      overrun_cnt_o,
    output logic [CNT_W-1:0]      drop_cnt_o,
    output logic                  timeout_flag_o
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    sched_state_t     state_q,   state_d;
    logic [DIV_W-1:0] cnt_q,     cnt_d;
    logic [DIV_W-1:0] eff_q,     eff_d;
    logic [WD_W-1:0]  wd_q,      wd_d;
    logic             start_q,   start_d;
    logic [CNT_W-1:0] overrun_q, overrun_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             tflag_q,   tflag_d;

    logic [DIV_W-1:0] eff_cfg;
    logic             tick, in_conv, expire, finish;
    logic             accept, pop, drop;
    logic             fifo_full, fifo_empty;
    logic [ADC_W-1:0] fifo_data;

    // ------------------------------------------------------------------
    // Period counter
    // ------------------------------------------------------------------
    assign eff_cfg = (period_cfg_i < DIV_W'(MIN_PERIOD)) ? DIV_W'(MIN_PERIOD) : period_cfg_i;
    assign tick    = (state_q != IDLE) && enable_i && (cnt_q == eff_q - 1'b1);

    always_comb begin
        cnt_d = cnt_q;
        eff_d = eff_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
            eff_d = eff_cfg;
        end else if (enable_i) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            // A new period_cfg is picked up only at a wrap.
            if (tick) eff_d = eff_cfg;
        end
    end

    // ------------------------------------------------------------------
    // Watchdog: counts cycles since start_conv while a conversion is open.
    // conv_done in the expiry cycle still counts as a normal completion.
    // ------------------------------------------------------------------
    assign in_conv = (state_q == BUSY) || (state_q == DRAIN);
    assign expire  = in_conv && !conv_done_i && (wd_q == WD_W'(TIMEOUT_CYCLES));
    assign finish  = in_conv && (conv_done_i || expire);
    assign wd_d    = in_conv ? wd_q + 1'b1 : '0;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (enable_i) state_d = ARMED;
            ARMED: begin
                if (!enable_i) state_d = IDLE;
                else if (tick) state_d = BUSY;
            end
            BUSY: begin
                if (finish)         state_d = enable_i ? ARMED : IDLE;
                else if (!enable_i) state_d = DRAIN;
            end
            DRAIN: if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // tick already implies enable_i, so this is "ARMED and period elapsed".
    assign start_d = (state_q == ARMED) && tick;

    // ------------------------------------------------------------------
    // Sample capture and FIFO
    // ------------------------------------------------------------------
    assign accept = in_conv && data_valid_i;
    assign pop    = m_if.m_valid && m_if.m_ready;
    assign drop   = accept && fifo_full && !pop;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADC_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (accept),
        .push_data_i (adc_data_i),
        .pop_i       (pop),
        .pop_data_o  (fifo_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Status: clear wins over a coincident increment.
    // ------------------------------------------------------------------
    always_comb begin
        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;
        tflag_d    = tflag_q;
        if (clr_status_i) begin
            overrun_d  = '0;
            drop_cnt_d = '0;
            tflag_d    = 1'b0;
        end else begin
            // Ticks only occur while enabled, so DRAIN never sees an overrun.
            if ((state_q == BUSY) && tick) overrun_d = sat_inc(overrun_q);
            if (drop)                      drop_cnt_d = sat_inc(drop_cnt_q);
            if (expire)                    tflag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            eff_q      <= DIV_W'(MIN_PERIOD);
            wd_q       <= '0;
            start_q    <= 1'b0;
            overrun_q  <= '0;
            drop_cnt_q <= '0;
            tflag_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            eff_q      <= eff_d;
            wd_q       <= wd_d;
            start_q    <= start_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
            tflag_q    <= tflag_d;
        end
    end

    assign start_conv_o   = start_q;
    assign busy_o         = in_conv;
    assign overrun_cnt_o  = overrun_q;
    assign drop_cnt_o     = drop_cnt_q;
    assign timeout_flag_o = tflag_q;
    assign m_if.m_data    = fifo_data;
    assign m_if.m_valid   = !fifo_empty;

endmodule

// File: tb/tb_ad_sample_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ad_sample_scheduler
// Directed bench for ad_sample_scheduler. A behavioural model (integer
// period phase, conversion-open flag, sample queue, clamped counters) is
// stepped on every rising edge and compared against all DUT outputs just
// after it; directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_ad_sample_scheduler;
    import ad_sched_pkg::*;

    localparam int DIV_W          = 20;
    localparam int MIN_PERIOD     = 128;
    localparam int TIMEOUT_CYCLES = 256;
    localparam int FIFO_DEPTH     = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic [DIV_W-1:0] period_cfg = '0;
    logic             clr_status = 1'b0;
    logic             conv_done = 1'b0;
    logic             data_valid = 1'b0;
    logic [ADC_W-1:0] adc_data = '0;
    logic             start_conv, busy, timeout_flag;
    logic [CNT_W-1:0] overrun_cnt, drop_cnt;

    ad_sample_scheduler_if bus ();

    always #4 clk = ~clk;

    ad_sample_scheduler #(
        .DIV_W          (DIV_W),
        .MIN_PERIOD     (MIN_PERIOD),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FIFO_DEPTH     (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable),
        .period_cfg_i   (period_cfg),
        .clr_status_i   (clr_status),
        .start_conv_o   (start_conv),
        .conv_done_i    (conv_done),
        .adc_data_i     (adc_data),
        .data_valid_i   (data_valid),
        .m_if           (bus),
        .busy_o         (busy),
        .overrun_cnt_o  (overrun_cnt),
        .drop_cnt_o     (drop_cnt),
        .timeout_flag_o (timeout_flag)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit preset_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------- behavioural model -------------------------
    bit               mo_on, mo_conv, mo_stop, mo_start, mo_tflag;
    int               mo_phase, mo_eff, mo_wd, mo_ov, mo_dr;
    logic [ADC_W-1:0] mo_q [$];

    function automatic int eff_of(input int p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

    task automatic model_step();
        bit tick, expire, finish, accept, pop, drop;
        if (rst) begin
            mo_on = 0; mo_conv = 0; mo_stop = 0; mo_start = 0; mo_tflag = 0;
            mo_phase = 0; mo_eff = MIN_PERIOD; mo_wd = 0; mo_ov = 0; mo_dr = 0;
            mo_q.delete();
            return;
        end
        tick   = mo_on && enable && (mo_phase == mo_eff - 1);
        expire = mo_conv && !conv_done && (mo_wd == TIMEOUT_CYCLES);
        finish = mo_conv && (conv_done || expire);
        accept = mo_conv && data_valid;
        pop    = (mo_q.size() > 0) && bus.m_ready;
        drop   = accept && !pop && (mo_q.size() == FIFO_DEPTH);
        if (pop) void'(mo_q.pop_front());
        if (accept && !drop) mo_q.push_back(adc_data);
        if (clr_status) begin
            mo_ov = 0; mo_dr = 0; mo_tflag = 0;
        end else begin
            if (tick && mo_conv && mo_ov < 65535) mo_ov++;
            if (drop && mo_dr < 65535) mo_dr++;
            if (expire) mo_tflag = 1;
        end
        if (preset_req) mo_dr = 65534;
        mo_start = tick && !mo_conv;
        if (!mo_on) begin
            if (enable) begin
                mo_on = 1; mo_phase = 0; mo_eff = eff_of(int'(period_cfg));
            end
        end else begin
            if (enable) begin
                if (tick) begin
                    mo_phase = 0; mo_eff = eff_of(int'(period_cfg));
                end else begin
                    mo_phase++;
                end
            end
            if (mo_conv) begin
                if (finish) begin
                    mo_conv = 0; mo_on = enable && !mo_stop; mo_stop = 0;
                end else begin
                    mo_wd++;
                    if (!enable) mo_stop = 1;
                end
            end else if (!enable) begin
                mo_on = 0;
            end else if (tick) begin
                mo_conv = 1; mo_wd = 0;
            end
        end
    endtask

    task automatic compare();
        check("start_conv", start_conv, mo_start);
        check("busy", busy, mo_conv);
        check("m_valid", bus.m_valid, mo_q.size() > 0);
        if (mo_q.size() > 0) check("m_data", bus.m_data, mo_q[0]);
        check("overrun_cnt", overrun_cnt, mo_ov);
        check("drop_cnt", drop_cnt, mo_dr);
        check("timeout_flag", timeout_flag, mo_tflag);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            compare();
        end
    end

    // ------------------------------ helpers ------------------------------
    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (start_conv) begin
                at = cyc;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_start: no start_conv within %0d cycles (cycle %0d)", budget, cyc);
    endtask

    // Completion plus result, delay cycles after the start_conv cycle.
    task automatic respond(input int delay, input logic [ADC_W-1:0] d);
        tick_n(delay);
        conv_done = 1'b1; data_valid = 1'b1; adc_data = d;
        @(negedge clk);
        conv_done = 1'b0; data_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "bench timeout");
    end

    // ------------------------------ stimulus -----------------------------
    initial begin
        int t0, s1, s2, nstart;
        bus.m_ready = 1'b1;
        tick_n(3);
        check("reset start_conv", start_conv, 0);
        check("reset busy", busy, 0);
        check("reset m_valid", bus.m_valid, 0);
        check("reset overrun", overrun_cnt, 0);
        check("reset drop", drop_cnt, 0);
        check("reset tflag", timeout_flag, 0);
        rst = 1'b0;
        tick_n(2);

        // 1: period 200, completion after 120 cycles
        period_cfg = 200; enable = 1'b1; t0 = cyc;
        wait_start(400, s1);
        check("t1 first start latency", s1 - t0, 201);
        for (int k = 0; k < 3; k++) begin
            respond(120, 12'h100 + 12'(k));
            wait_start(400, s2);
            check("t1 start spacing", s2 - s1, 200);
            s1 = s2;
        end
        respond(120, 12'h1FF);
        check("t1 overrun", overrun_cnt, 0);

        // 2: period 50 -> 128, then a conversion that never completes in time
        enable = 1'b0; tick_n(2);
        period_cfg = 50; enable = 1'b1; t0 = cyc;
        wait_start(400, s1);
        check("t2 first start latency", s1 - t0, 129);
        respond(20, 12'h200);
        wait_start(400, s2);
        check("t2 start spacing", s2 - s1, 128);
        s1 = s2;
        tick_n(300);
        conv_done = 1'b1; data_valid = 1'b1; adc_data = 12'h7FF;
        @(negedge clk);
        conv_done = 1'b0; data_valid = 1'b0;
        check("t2 timeout flag", timeout_flag, 1);
        check("t2 busy after timeout", busy, 0);
        check("t2 late data ignored", bus.m_valid, 0);
        check("t2 overrun", overrun_cnt, 2);
        wait_start(400, s2);
        check("t2 restart spacing", s2 - s1, 384);
        respond(20, 12'h201);
        pulse_clr();
        check("t2 clr tflag", timeout_flag, 0);
        check("t2 clr overrun", overrun_cnt, 0);

        // 3: period 128, completion after 200 -> every other tick skipped
        enable = 1'b0; tick_n(2);
        period_cfg = 128; enable = 1'b1;
        wait_start(400, s1);
        for (int k = 1; k <= 2; k++) begin
            respond(200, 12'h300 + 12'(k));
            wait_start(400, s2);
            check("t3 start spacing", s2 - s1, 256);
            check("t3 overrun", overrun_cnt, k);
            s1 = s2;
        end
        respond(20, 12'h3FF);

        // 4: consumer stalled, five samples into a four-deep FIFO
        pulse_clr();
        bus.m_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            wait_start(400, s1);
            respond(20, 12'(k));
        end
        enable = 1'b0;
        check("t4 drop count", drop_cnt, 1);
        tick_n(2);
        bus.m_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("t4 drain valid", bus.m_valid, 1);
            check("t4 drain order", bus.m_data, k);
            @(negedge clk);
        end
        check("t4 drained empty", bus.m_valid, 0);

        // 5: enable dropped mid-conversion
        pulse_clr();
        period_cfg = 128; enable = 1'b1;
        wait_start(400, s1);
        tick_n(10);
        enable = 1'b0;
        tick_n(100);
        check("t5 busy held in drain", busy, 1);
        tick_n(10);
        conv_done = 1'b1; data_valid = 1'b1; adc_data = 12'hABC;
        @(negedge clk);
        conv_done = 1'b0; data_valid = 1'b0;
        check("t5 sample valid", bus.m_valid, 1);
        check("t5 sample data", bus.m_data, 12'hABC);
        check("t5 busy released", busy, 0);
        nstart = 0;
        repeat (400) begin
            @(negedge clk);
            if (start_conv) nstart++;
        end
        check("t5 no start after drain", nstart, 0);

        // 6: drop counter saturation, clear vs drop, reset mid-conversion
        bus.m_ready = 1'b0;
        pulse_clr();
        force dut.drop_cnt_q = 16'hFFFE;
        preset_req = 1'b1;
        @(negedge clk);
        release dut.drop_cnt_q;
        preset_req = 1'b0;
        check("t6 preset", drop_cnt, 16'hFFFE);
        enable = 1'b1;
        wait_start(400, s1);
        tick_n(3);
        for (int i = 0; i < 8; i++) begin
            data_valid = 1'b1; adc_data = 12'h600 + 12'(i);
            @(negedge clk);
        end
        data_valid = 1'b0;
        check("t6 drop saturated", drop_cnt, 16'hFFFF);
        data_valid = 1'b1; clr_status = 1'b1;
        @(negedge clk);
        data_valid = 1'b0; clr_status = 1'b0;
        check("t6 clear beats drop", drop_cnt, 0);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        wait_start(400, s1);
        tick_n(5);
        rst = 1'b1;
        @(negedge clk);
        check("t6 rst start_conv", start_conv, 0);
        check("t6 rst busy", busy, 0);
        check("t6 rst m_valid", bus.m_valid, 0);
        check("t6 rst overrun", overrun_cnt, 0);
        check("t6 rst drop", drop_cnt, 0);
        check("t6 rst tflag", timeout_flag, 0);
        rst = 1'b0;
        tick_n(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
